// File: rtl/ejtag_sync_filter.sv
// ejtag_sync_filter: multi-channel CDC synchronizer with optional debounce
// filter and one-cycle rise/fall pulses on every accepted transition.
`default_nettype none

module ejtag_sync_filter #(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("ejtag_sync_filter: STAGES must be in 2..4");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("ejtag_sync_filter: WIDTH must be in 1..32");
  end
  if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
    $error("ejtag_sync_filter: FILTER must be in 0..255");
  end

  logic [WIDTH-1:0] sync [STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] od;

  // Pure flop chain: only the last stage fans out.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < STAGES; k++) sync[k] <= RESET_VAL;
    end else begin
      sync[0] <= IN;
      for (int k = 1; k < STAGES; k++) sync[k] <= sync[k-1];
    end
  end

  assign s = sync[STAGES-1];

  if (FILTER == 0) begin : g_bypass
    assign filt = s;
  end else begin : g_filter
    localparam int             CW   = $clog2(FILTER + 1);
    localparam logic [CW-1:0]  LAST = CW'(FILTER - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic          f_q;
      logic [CW-1:0] cnt;

      // Any return of s to the held level discards the accumulated count.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          f_q <= RESET_VAL[i];
          cnt <= '0;
        end else if (s[i] == f_q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          f_q <= s[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign filt[i] = f_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) od <= RESET_VAL;
    else          od <= filt;
  end

  assign OUT  = filt;
  assign RISE = filt & ~od;
  assign FALL = ~filt & od;

endmodule

`default_nettype wire

// File: doc/ejtag_sync_filter.md
# ejtag_sync_filter

Parametrised multi-channel synchronizer for asynchronous EJTAG-side and pad-level control signals entering the CLK domain. Each channel passes through a configurable-depth flop chain, then an optional debounce filter that rejects pulses shorter than a programmable number of cycles, and produces a one-cycle rise/fall pulse on every accepted transition. It replaces hand-instantiated 2-flop synchronizers wherever several related asynchronous inputs need aligned, glitch-free, edge-annotated versions.

## Interface
Parameters:
- WIDTH, 4: number of independent channels, 1..32.
- STAGES, 2: synchronizer flop depth, 2..4. Values outside this range must fail elaboration.
- FILTER, 3: debounce length in cycles, 0..255. 0 bypasses the filter.
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset level of every internal flop and of OUT.

Ports:
- CLK  input  1  sole clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset; async assert, deasserted externally synchronous to CLK.
- IN  input  WIDTH  asynchronous inputs, no timing relation to CLK.
- OUT  output  WIDTH  synchronized, filtered level per channel.
- RISE  output  WIDTH  one-cycle pulse when OUT[i] goes 0->1.
- FALL  output  WIDTH  one-cycle pulse when OUT[i] goes 1->0.

## Operation
- Per-channel chain sync[0..STAGES-1]: sync[0] <= IN[i], sync[k] <= sync[k-1]. S = sync[STAGES-1]. No logic between chain flops; no fan-out from any stage except the last.
- FILTER = 0: filtered state F = S (no extra flop, no counter). STAGES=2/FILTER=0 is cycle-identical to the legacy 2-flop synchronizer.
- FILTER > 0: per channel a flop F and counter C, width clog2(FILTER+1) bits.
  - S == F: C <= 0.
  - S != F and C == FILTER-1: F <= S, C <= 0.
  - S != F otherwise: C <= C+1.
  - Effect: S must differ from F on FILTER consecutive edges before F follows. Any return of S to F resets C; no partial credit carries over.
- OUT = F.
- Edge detect: OD[i] <= OUT[i] each edge. RISE = OUT & ~OD; FALL = ~OUT & OD. Both are combinational from flops only and are mutually exclusive per channel.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses. No cross-channel coherency is guaranteed: bits may resolve one cycle apart due to metastability.
- Reset (RESET_N low), effective immediately, asynchronous:
  - all sync stages, F and OD = RESET_VAL; C = 0.
  - OUT = RESET_VAL; RISE = FALL = 0.
  - IN is ignored while in reset.
  - First cycle after release: no RISE/FALL, even if IN differs from RESET_VAL. Transition pulses appear only after the normal latency.

## Timing
- IN change meeting setup before edge E1: S changes after STAGES edges, at E_STAGES.
- FILTER = 0: OUT changes at E_STAGES.
- FILTER > 0: OUT changes at E_(STAGES+FILTER).
- RISE/FALL are asserted for exactly the one cycle in which OUT first shows the new level.
- Uncertainty: ±1 cycle due to metastable resolution in sync[0].
- Minimum accepted pulse width at S: FILTER cycles. A pulse of FILTER-1 cycles or less never reaches OUT.
- Maximum toggle rate at OUT: one transition per FILTER cycles (per cycle when FILTER = 0).
- Counter never exceeds FILTER-1; no wrap-around is possible.

## Test plan
- Reset (WIDTH=4, STAGES=2, FILTER=3, RESET_VAL=4'hA), IN=4'h5 during reset -> OUT=4'hA, RISE=FALL=0 in reset and on first cycle after release. OUT=4'h5 at edge 5 after release, FALL=4'hA and RISE=4'h5 for that one cycle.
- RESET_VAL=0, IN[0] 0->1 held -> OUT[0]=1 exactly 5 edges later, RISE=4'h1 for one cycle, other bits and FALL stay 0.
- Glitch rejection: IN[1] high for 2 cycles, then low -> OUT[1] stays 0, no pulses. IN[1] high for 3 cycles -> OUT[1] high for 3 cycles with one RISE and one FALL.
- Interrupted count: S[2] high 2 cycles, low 1 cycle, high 3 cycles -> OUT[2] rises only after the second high run's 3rd cycle (C restarted from 0).
- Bypass (STAGES=3, FILTER=0): random IN stream -> OUT equals IN delayed exactly 3 edges. RISE/FALL match the delayed-IN edges. STAGES=2/FILTER=0 matches the legacy 2-flop model bit-for-bit.
- Async reset mid-count: RESET_N low between edges while C=2 on channel 3 -> OUT, C and OD cleared before the next edge, RISE/FALL=0 immediately. After release with IN=0, no pulse ever appears.
